// File: rtl/ab_ff_bank.sv
// ab_ff_bank -- WIDTH independent AB flip-flops on one clock, with a parallel
// load, a global enable, per-bit change flags and a saturating transition
// counter.
//
// AB code per channel: 00 hold, 01 set, 10 clear, 11 toggle.
// The load input has priority over en. When neither is active, Q holds.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   en                  enable for the AB update
//   load, load_val      synchronous parallel load (overrides A/B and en)
//   A, B                per-channel AB controls
//   clr_cnt             synchronous clear of change_cnt / cnt_sat
//   Q                   registered flip-flop outputs
//   changed             registered mask of bits that flipped on the last edge
//   change_cnt          saturating running count of bit transitions
//   cnt_sat             sticky flag: change_cnt reached its maximum
//   parity, parity_err  only when AB_FF_BANK_PARITY_EN is defined:
//                       registered ^Q and a sticky stored-vs-recomputed mismatch
//
// Optional feature macro: AB_FF_BANK_PARITY_EN (default build leaves it undefined).

// Next-state function for a single AB channel.
module ab_ff_lane (
    input  logic a,
    input  logic b,
    input  logic q,
    output logic q_nxt
);
    always_comb begin
        case ({a, b})
            2'b00:   q_nxt = q;
            2'b01:   q_nxt = 1'b1;
            2'b10:   q_nxt = 1'b0;
            default: q_nxt = ~q;
        endcase
    end
endmodule

module ab_ff_bank #(
    parameter int               WIDTH     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] change_cnt,
    output logic             cnt_sat
`ifdef AB_FF_BANK_PARITY_EN
    ,
    output logic             parity,
    output logic             parity_err
`endif
);
    // Popcount width, and an adder wide enough that neither the count nor a
    // full-width popcount can wrap before the saturation compare.
    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [WIDTH-1:0] ab_nxt;
    logic [WIDTH-1:0] diff;
    logic [PC_W-1:0]  pop;
    logic [SUM_W-1:0] sum;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ab_ff_lane u_lane (
            .a    (A[i]),
            .b    (B[i]),
            .q    (q_q[i]),
            .q_nxt(ab_nxt[i])
        );
    end

    // The mux keeps A/B out of the next state unless en=1, so unknowns on
    // A/B during a hold cycle cannot reach Q.
    always_comb begin
        q_d = q_q;
        if (load)
            q_d = load_val;
        else if (en)
            q_d = ab_nxt;
    end

    always_comb begin
        diff      = q_d ^ q_q;
        changed_d = diff;
        pop       = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + PC_W'(diff[i]);
        sum = SUM_W'(cnt_q) + SUM_W'(pop);
    end

    // Clear wins over any transitions on the same edge. Once the count is
    // pinned at its maximum, the sum stays at or above it, so cnt_sat holds.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (sum >= CNT_MAX) begin
            cnt_d = CNT_MAX[CNT_W-1:0];
            sat_d = 1'b1;
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            changed_q <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
        end
    end

    assign Q          = q_q;
    assign changed    = changed_q;
    assign change_cnt = cnt_q;
    assign cnt_sat    = sat_q;

`ifdef AB_FF_BANK_PARITY_EN
    logic parity_q, parity_d;
    logic perr_q, perr_d;

    // The stored parity is taken from the next state. It is checked one
    // cycle later against parity recomputed from the held Q. A mismatch
    // means an upset in either register.
    always_comb begin
        parity_d = ^q_d;
        perr_d   = perr_q | ((^q_q) != parity_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= ^RESET_VAL;
            perr_q   <= 1'b0;
        end else begin
            parity_q <= parity_d;
            perr_q   <= perr_d;
        end
    end

    assign parity     = parity_q;
    assign parity_err = perr_q;
`endif

endmodule
